uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Board-side endpoint of the PC command link; the PC/host is the initiator.
- Deserialises host bytes on one UART line and implements the arm-then-command protocol: 'e' (0x65) arms, the next byte is the command.
- Serialises the reply on a second line; all bit-level RX/TX logic is internal, 8N1, LSB first, idle high.
- Used as the b1/b2 board model behind the MITM and as a standalone board responder.

Parameters:
- SYSTEM_CLOCK, 32000000, clk frequency in Hz.
- BAUD_RATE, 9600, line rate. CYC = SYSTEM_CLOCK/BAUD_RATE (integer division; 3333 at defaults).
- MAX_REPLY, 8, largest legal command value, range 1..15.
- TIMEOUT_BITS, 64, bit-times the responder waits in ARMED before it disarms.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_bus  in  1  serial line from host. Asynchronous; passes through a 2-flop synchroniser.
- tx_bus  out  1  serial reply line to host.
- resp_base  in  8  reply pattern base, sampled when cmd_valid pulses.
- armed  out  1  high while in ARMED.
- busy  out  1  high while a reply is being transmitted.
- cmd_valid  out  1  one-cycle pulse when a command byte is accepted.
- cmd_data  out  8  last accepted command byte; held until the next accept.
- err_count  out  8  saturating count of framing errors and dropped bytes.

Behaviour:
- Reset values: tx_bus=1, armed=0, busy=0, cmd_valid=0, cmd_data=0, err_count=0; FSM=IDLE; RX and TX datapaths idle.
- Reset mid-byte aborts any RX or TX immediately; tx_bus returns to 1 asynchronously.
- RX start detection: a falling edge on the synchronised line starts a counter. Sample at CYC/2.
  - If the line is high at that sample, treat it as a glitch and return to hunt; err_count is not changed.
- RX data: 8 data bits sampled every CYC, then the stop bit.
  - Stop=0 is a framing error: discard the byte, err_count+1.
  - A byte is "received" at its stop-bit sample.
- FSM IDLE: received 0x65 -> ARMED. Any other byte is ignored, no count.
- FSM ARMED: armed=1.
  - 0x65 -> stay ARMED and restart the timeout.
  - Any other byte: cmd_valid=1 for one cycle, cmd_data=byte, resp_base latched, -> REPLY.
  - TIMEOUT_BITS*CYC cycles with no received byte -> IDLE.
- FSM REPLY: busy=1. The first start bit (tx_bus=0) is driven exactly 2 cycles after the cmd_valid cycle.
  - If 1 <= cmd <= MAX_REPLY: send cmd bytes, values resp_base+i for i = 0..cmd-1, mod 256.
  - Otherwise send a single NAK, 0x15.
  - Each bit lasts exactly CYC cycles. The next start bit follows the previous stop bit with no gap.
  - When the final stop bit completes: busy=0 -> IDLE. A new 'e' is required to re-arm.
- Bytes received while in REPLY are dropped, err_count+1, and do not affect the FSM.
- err_count saturates at 0xFF. A framing error and a drop in the same cycle count once.

Optional Feature:
- Macro: RESP_CHECKSUM_EN.
- Defined: after the last reply byte (including a NAK), one extra byte is sent equal to the XOR of all reply bytes. busy stays high until its stop bit ends.
- Undefined: no checksum byte is sent; the reply is exactly as described above.

Test Plan:
- Send 0x65, then 0x03, with resp_base=0x40 -> cmd_valid pulses once and cmd_data=0x03. tx_bus carries 0x40, 0x41, 0x42, with the first start edge 2 clk after cmd_valid. With RESP_CHECKSUM_EN, a fourth byte 0x43 follows.
- Send 0x03 without arming -> no cmd_valid, tx_bus stays 1, err_count=0.
- Send 0x65, then 0x20 -> single reply byte 0x15 (NAK); with RESP_CHECKSUM_EN, a second byte 0x15. FSM ends in IDLE.
- Send 0x65, then hold rx_bus idle for 64*3333 cycles -> armed falls to 0. A following 0x03 produces no reply.
- Send 0x65, then a byte with stop bit=0 -> err_count=1 and still armed. While a 0x08 reply is running, send 0x55 -> err_count=2 and the reply completes unaltered.
- Send 0x65, 0x08 with resp_base=0xFE; assert rst low during the third reply byte -> tx_bus=1 at once and all outputs return to reset values. After release, 0x65, 0x01 gives reply 0xFE.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: 8N1 UART board responder; 'e' arms, the next byte is a command answered on tx_bus.
// Optional RESP_CHECKSUM_EN appends an XOR checksum byte to every reply.
module uart_cmd_responder #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE = 9600,
    parameter int MAX_REPLY = 8,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bus,
    output logic       tx_bus,
    input  logic [7:0] resp_base,
    output logic       armed,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    output logic [7:0] err_count
);
    localparam int CYC = SYSTEM_CLOCK / BAUD_RATE;
    localparam int CW = $clog2(CYC + 1);
    localparam int TO = TIMEOUT_BITS * CYC;
    localparam int TW = $clog2(TO + 1);
    localparam logic [CW-1:0] CYC_M1 = CW'(CYC - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CYC / 2 - 1);
    localparam logic [TW-1:0] TO_M1 = TW'(TO - 1);
    localparam logic [7:0] MAXR = 8'(MAX_REPLY);
    localparam logic [7:0] ARM = 8'h65;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [1:0] {IDLE, ARMED, REPLY} state_t;
    state_t state, state_nx;

    logic rx_s1, rx_s2, rx_prev, rx_active;
    logic [CW-1:0] rx_cnt;
    logic [3:0] rx_bit;
    logic [7:0] rx_sh;
    logic rx_tick, rx_ok, frame_err, cmd_hit, err_inc;
    logic [TW-1:0] to_cnt;

    logic tx_go, tx_active, cmd_ok, tx_end, tx_done, tx_load;
    logic [CW-1:0] tx_cnt;
    logic [3:0] tx_bit;
    logic [8:0] tx_sh;
    logic [4:0] tx_idx, n_data, tx_total;
    logic [7:0] base, csum, data_byte, tx_byte;

    // rx_sh holds start+data while shifting; after 9 shifts it is exactly the data byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_prev <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
        end else begin
            rx_s1 <= rx_bus;
            rx_s2 <= rx_s1;
            rx_prev <= rx_s2;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt <= HALF_M1;
                    rx_bit <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CYC_M1;
                rx_bit <= rx_bit + 4'd1;
                if ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9) rx_active <= 1'b0;
                else rx_sh <= {rx_s2, rx_sh[7:1]};
            end
        end
    end

    assign rx_tick = rx_active && rx_cnt == '0 && rx_bit == 4'd9;
    assign rx_ok = rx_tick && rx_s2;
    assign frame_err = rx_tick && !rx_s2;
    assign err_inc = frame_err || (rx_ok && state == REPLY);

    always_comb begin
        state_nx = state;
        cmd_hit = 1'b0;
        armed = state == ARMED;
        busy = state == REPLY;
        case (state)
            IDLE: state_nx = (rx_ok && rx_sh == ARM) ? ARMED : IDLE;
            ARMED: begin
                cmd_hit = rx_ok && rx_sh != ARM;
                state_nx = cmd_hit ? REPLY : (!rx_ok && to_cnt == TO_M1) ? IDLE : ARMED;
            end
            REPLY: state_nx = tx_done ? IDLE : REPLY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cmd_valid <= 1'b0;
            cmd_data <= '0;
            err_count <= '0;
            to_cnt <= '0;
        end else begin
            state <= state_nx;
            cmd_valid <= cmd_hit;
            if (cmd_hit) cmd_data <= rx_sh;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
            to_cnt <= (state != ARMED || rx_ok) ? '0 : to_cnt + 1'b1;
        end
    end

    assign cmd_ok = cmd_data != 8'd0 && cmd_data <= MAXR;
    assign n_data = cmd_ok ? cmd_data[4:0] : 5'd1;
    assign data_byte = cmd_ok ? base + {3'b0, tx_idx} : NAK;
`ifdef RESP_CHECKSUM_EN
    assign tx_total = n_data + 5'd1;
    assign tx_byte = (tx_idx == n_data) ? csum : data_byte;
`else
    assign tx_total = n_data;
    assign tx_byte = data_byte;
`endif
    assign tx_end = tx_active && tx_cnt == '0 && tx_bit == 4'd9;
    assign tx_done = tx_end && tx_idx == tx_total;
    assign tx_load = tx_go || (tx_end && tx_idx != tx_total);

    // tx_idx counts bytes already loaded, so it also indexes the next byte to send
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_bus <= 1'b1;
            tx_go <= 1'b0;
            tx_active <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= '1;
            tx_idx <= '0;
            base <= '0;
            csum <= '0;
        end else if (cmd_valid) begin
            base <= resp_base;
            csum <= '0;
            tx_idx <= '0;
            tx_go <= 1'b1;
        end else if (tx_load) begin
            tx_go <= 1'b0;
            tx_active <= 1'b1;
            tx_bus <= 1'b0;
            tx_sh <= {1'b1, tx_byte};
            tx_cnt <= CYC_M1;
            tx_bit <= '0;
            tx_idx <= tx_idx + 5'd1;
            csum <= csum ^ tx_byte;
        end else if (tx_active) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bit == 4'd9) begin
                tx_active <= 1'b0;
            end else begin
                tx_bus <= tx_sh[0];
                tx_sh <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 4'd1;
                tx_cnt <= CYC_M1;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed stimulus with a queue scoreboard for cmd_valid and decoded tx_bus bytes.
module tb_uart_cmd_responder;
    localparam int BIT = 16;

    logic clk = 1'b0, rst = 1'b0, rx_bus = 1'b1;
    logic [7:0] resp_base = 8'h00;
    logic tx_bus, armed, busy, cmd_valid;
    logic [7:0] cmd_data, err_count;

    int compared = 0, mismatched = 0, cyc = 0;
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_tx[$];
    bit mon_on = 0, tx_prev = 1, due_pend = 0;
    int mon_cnt = 0, due_cyc = 0, start_cyc = 0, k = 0;
    logic [7:0] mon_byte = 8'h00;

    uart_cmd_responder #(.SYSTEM_CLOCK(160), .BAUD_RATE(10)) dut (
        .clk(clk), .rst(rst), .rx_bus(rx_bus), .tx_bus(tx_bus), .resp_base(resp_base),
        .armed(armed), .busy(busy), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations when cmd_valid pulses or a tx byte completes
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mon_on = 0;
            due_pend = 0;
            tx_prev = 1;
        end else begin
            if (cmd_valid) begin
                check("cmd_expected", int'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0) check("cmd_data", cmd_data, exp_cmd.pop_front());
                due_cyc = cyc + 2;
                due_pend = 1;
            end
            if (mon_on) begin
                mon_cnt++;
                if (mon_cnt % BIT == BIT / 2) begin
                    k = mon_cnt / BIT;
                    if (k == 0) check("tx_start_bit", tx_bus, 0);
                    else if (k <= 8) mon_byte[k-1] = tx_bus;
                    else begin
                        mon_on = 0;
                        check("tx_stop_bit", tx_bus, 1);
                        check("tx_expected", int'(exp_tx.size() != 0), 1);
                        if (exp_tx.size() != 0) begin
                            check("tx_byte", mon_byte, exp_tx.pop_front());
                            if (exp_tx.size() != 0) begin
                                due_cyc = start_cyc + 10 * BIT;
                                due_pend = 1;
                            end
                        end
                    end
                end
            end else if (tx_prev && !tx_bus) begin
                mon_on = 1;
                mon_cnt = 0;
                start_cyc = cyc;
                if (due_pend) check("tx_start_cycle", cyc, due_cyc);
                due_pend = 0;
            end
            tx_prev = tx_bus;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
        @(negedge clk);
        rx_bus = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bus = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx_bus = stop;
        repeat (BIT) @(negedge clk);
        rx_bus = 1'b1;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((busy || exp_tx.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("reply_done", int'(busy || exp_tx.size() != 0), 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_tx_bus", tx_bus, 1);
        check("rst_armed", armed, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_err_count", err_count, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // arm, command 3 with base 0x40
        resp_base = 8'h40;
        send_byte(8'h65);
        @(negedge clk);
        check("t1_armed", armed, 1);
        exp_cmd.push_back(8'h03);
        exp_tx.push_back(8'h40); exp_tx.push_back(8'h41); exp_tx.push_back(8'h42);
`ifdef RESP_CHECKSUM_EN
        exp_tx.push_back(8'h43);
`endif
        send_byte(8'h03);
        check("t1_busy", busy, 1);
        wait_done(2000);
        check("t1_idle", armed, 0);
        check("t1_cmd_held", cmd_data, 8'h03);
        check("t1_err", err_count, 0);

        // unarmed command and a short glitch: no reply, no error
        send_byte(8'h03);
        rx_bus = 1'b0;
        repeat (3) @(negedge clk);
        rx_bus = 1'b1;
        repeat (200) @(negedge clk);
        check("t2_armed", armed, 0);
        check("t2_busy", busy, 0);
        check("t2_tx_idle", tx_bus, 1);
        check("t2_err", err_count, 0);

        // out-of-range command gives NAK
        send_byte(8'h65);
        exp_cmd.push_back(8'h20);
        exp_tx.push_back(8'h15);
`ifdef RESP_CHECKSUM_EN
        exp_tx.push_back(8'h15);
`endif
        send_byte(8'h20);
        wait_done(2000);
        check("t3_armed", armed, 0);
        check("t3_busy", busy, 0);
        check("t3_cmd_data", cmd_data, 8'h20);

        // timeout: 64 bit-times in ARMED disarms
        send_byte(8'h65);
        repeat (900) @(negedge clk);
        check("t4_still_armed", armed, 1);
        repeat (200) @(negedge clk);
        check("t4_disarmed", armed, 0);
        send_byte(8'h03);
        repeat (200) @(negedge clk);
        check("t4_no_reply", busy, 0);
        check("t4_err", err_count, 0);

        // re-arm, framing error, then a drop during an 8-byte reply
        send_byte(8'h65);
        send_byte(8'h65);
        check("t5_rearmed", armed, 1);
        send_byte(8'h33, 1'b0);
        repeat (20) @(negedge clk);
        check("t5_frame_err", err_count, 1);
        check("t5_armed", armed, 1);
        resp_base = 8'h10;
        exp_cmd.push_back(8'h08);
        exp_tx.push_back(8'h10); exp_tx.push_back(8'h11); exp_tx.push_back(8'h12); exp_tx.push_back(8'h13);
        exp_tx.push_back(8'h14); exp_tx.push_back(8'h15); exp_tx.push_back(8'h16); exp_tx.push_back(8'h17);
`ifdef RESP_CHECKSUM_EN
        exp_tx.push_back(8'h00);
`endif
        send_byte(8'h08);
        send_byte(8'h55);
        check("t5_drop_err", err_count, 2);
        check("t5_busy", busy, 1);
        wait_done(3000);
        check("t5_err_final", err_count, 2);
        check("t5_idle", armed, 0);

        // reset during the third reply byte, base 0xFE wraps
        resp_base = 8'hFE;
        exp_cmd.push_back(8'h08);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hFF);
        send_byte(8'h65);
        send_byte(8'h08);
        for (int n = 0; n < 1000 && exp_tx.size() != 0; n++) @(negedge clk);
        check("t6_two_bytes", exp_tx.size(), 0);
        repeat (70) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_tx_bus", tx_bus, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_armed", armed, 0);
        check("t6_rst_cmd_valid", cmd_valid, 0);
        check("t6_rst_cmd_data", cmd_data, 0);
        check("t6_rst_err", err_count, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        exp_cmd.push_back(8'h01);
        exp_tx.push_back(8'hFE);
`ifdef RESP_CHECKSUM_EN
        exp_tx.push_back(8'hFE);
`endif
        send_byte(8'h65);
        send_byte(8'h01);
        wait_done(2000);
        check("t6_idle", armed, 0);
        check("queues_drained", exp_cmd.size() + exp_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
